// File: rtl/imu_spi_responder.sv
// imu_spi_responder
//   Emulates the IMU side of an SPI mode-3 link. Sampling is MSB first. MOSI is
//   sampled on sck rising edges, and MISO is changed on sck falling edges. The
//   block sits in front of a 128 x 8 register file that a host port can also
//   write and read.
//
//   The first byte of a frame is a command byte: bit7 = 1 for a read, and
//   bits[6:0] = start address. Every following byte reads or writes the current
//   address, then the address increments and wraps from 127 to 0. The identity
//   register (WHOAMI_ADDR) always reads WHOAMI_VAL. Writes to it are dropped.
//
// Ports
//   clk, rst_n            system clock, synchronous active-low reset
//   spi_sck/ss/mosi       SPI inputs, asynchronous to clk
//   spi_miso              SPI data out (1 when idle and during the command byte)
//   frame_active          high while the FSM is outside IDLE
//   host_we/addr/wdata    host register write port
//   host_rdata            register[host_addr], one clk of latency
//   reg_wr_valid/addr/data one-clk notification for each SPI-written byte
module imu_spi_responder #(
  parameter logic [6:0] WHOAMI_ADDR = 7'h75,
  parameter logic [7:0] WHOAMI_VAL  = 8'h71
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_ss,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       frame_active,
  input  logic       host_we,
  input  logic [6:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       reg_wr_valid,
  output logic [6:0] reg_wr_addr,
  output logic [7:0] reg_wr_data
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  // Synchronizer bit order: [0] = sck, [1] = ss, [2] = mosi.
  // The ss flops reset to "low". If ss is already low when reset is released,
  // this does not look like a falling edge, so no frame starts until ss has
  // been seen high first. The sck flops reset to its idle-high level.
  localparam logic [2:0] SYNC_RST = 3'b001;

  logic [2:0] meta_reg;
  logic [2:0] sync_reg;
  logic [1:0] prev_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_reg <= SYNC_RST;
      sync_reg <= SYNC_RST;
      prev_reg <= SYNC_RST[1:0];
    end else begin
      meta_reg <= {spi_mosi, spi_ss, spi_sck};
      sync_reg <= meta_reg;
      prev_reg <= sync_reg[1:0];
    end
  end

  logic sck_rise;
  logic sck_fall;
  logic ss_high;
  logic ss_fall;
  logic mosi_s;

  assign sck_rise = sync_reg[0] & ~prev_reg[0];
  assign sck_fall = ~sync_reg[0] & prev_reg[0];
  assign ss_high  = sync_reg[1];
  assign ss_fall  = ~sync_reg[1] & prev_reg[1];
  assign mosi_s   = sync_reg[2];

  // Frame state
  state_t     state_reg;
  logic [2:0] bit_cnt_reg;
  logic [6:0] shift_in_reg;   // first seven bits of the byte being received
  logic [7:0] shift_out_reg;  // read snapshot being shifted onto MISO
  logic       rw_reg;         // 1 = read frame
  logic [6:0] addr_reg;
  logic       miso_reg;

  logic [7:0] mem [128];

  logic [7:0] byte_in;
  logic       byte_done;
  logic       spi_wr;
  logic       host_wr;
  logic [6:0] addr_inc;

  // The eighth bit is taken directly from the synchronizer.
  // This lets the completed byte be acted on in the same clk as its last sck edge.
  assign byte_in   = {shift_in_reg, mosi_s};
  assign byte_done = sck_rise && !ss_high && (bit_cnt_reg == 3'd7);
  assign spi_wr    = (state_reg == DATA) && byte_done && !rw_reg
                     && (addr_reg != WHOAMI_ADDR);
  assign host_wr   = host_we && (host_addr != WHOAMI_ADDR);
  assign addr_inc  = addr_reg + 7'd1;  // 7-bit add wraps from 127 to 0

  assign spi_miso     = miso_reg;
  assign frame_active = (state_reg != IDLE);

  // Register file and host read port.
  // The SPI write is issued after the host write. On a same-address collision,
  // the SPI data therefore lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) begin
        mem[i] <= (7'(i) == WHOAMI_ADDR) ? WHOAMI_VAL : 8'h00;
      end
      host_rdata <= 8'h00;
    end else begin
      if (host_wr) begin
        mem[host_addr] <= host_wdata;
      end
      if (spi_wr) begin
        mem[addr_reg] <= byte_in;
      end
      host_rdata <= mem[host_addr];
    end
  end

  // Frame FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= 3'd0;
      shift_in_reg  <= 7'd0;
      shift_out_reg <= 8'hFF;
      rw_reg        <= 1'b0;
      addr_reg      <= 7'd0;
      miso_reg      <= 1'b1;
      reg_wr_valid  <= 1'b0;
      reg_wr_addr   <= 7'd0;
      reg_wr_data   <= 8'h00;
    end else begin
      reg_wr_valid <= 1'b0;
      if (ss_high) begin
        // Deselect ends the frame from any state.
        // Any partially received byte is thrown away.
        state_reg     <= IDLE;
        bit_cnt_reg   <= 3'd0;
        shift_in_reg  <= 7'd0;
        shift_out_reg <= 8'hFF;
        miso_reg      <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            if (ss_fall) begin
              state_reg   <= CMD;
              bit_cnt_reg <= 3'd0;
              miso_reg    <= 1'b1;
            end
          end

          CMD: begin
            if (sck_rise) begin
              shift_in_reg <= byte_in[6:0];
              bit_cnt_reg  <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                rw_reg    <= byte_in[7];
                addr_reg  <= byte_in[6:0];
                state_reg <= DATA;
                // Take the read snapshot now. Its MSB goes out on the next sck fall.
                shift_out_reg <= byte_in[7] ? mem[byte_in[6:0]] : 8'hFF;
              end
            end
          end

          DATA: begin
            if (sck_fall) begin
              miso_reg      <= shift_out_reg[7];
              shift_out_reg <= {shift_out_reg[6:0], 1'b1};
            end
            if (sck_rise) begin
              shift_in_reg <= byte_in[6:0];
              bit_cnt_reg  <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                addr_reg      <= addr_inc;
                shift_out_reg <= rw_reg ? mem[addr_inc] : 8'hFF;
                if (spi_wr) begin
                  reg_wr_valid <= 1'b1;
                  reg_wr_addr  <= addr_reg;
                  reg_wr_data  <= byte_in;
                end
              end
            end
          end

          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imu_spi_responder.sv
// Directed testbench for imu_spi_responder.
// An SPI mode-3 master runs with 10-clk sck half periods.
// Expected MISO bytes and register-write pulses are queued when stimulus is
// driven. They are compared as the DUT produces them.
module tb_imu_spi_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sck = 1'b1;
  logic       spi_ss = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       frame_active;
  logic       host_we = 1'b0;
  logic [6:0] host_addr = 7'h00;
  logic [7:0] host_wdata = 8'h00;
  logic [7:0] host_rdata;
  logic       reg_wr_valid;
  logic [6:0] reg_wr_addr;
  logic [7:0] reg_wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] miso_q[$];

  always #5 clk = ~clk;

  imu_spi_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_sck      (spi_sck),
    .spi_ss       (spi_ss),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .frame_active (frame_active),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_rdata   (host_rdata),
    .reg_wr_valid (reg_wr_valid),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register-write pulse monitor. Each pulse pops one expectation.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && reg_wr_valid) begin
      n_checks++;
      assert (wr_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_wr: observed addr %0h data %0h expected no pulse",
               reg_wr_addr, reg_wr_data);
      end
      if (wr_q.size() > 0) begin
        e = wr_q.pop_front();
        check("wr_addr", 16'(reg_wr_addr), 16'(e.a));
        check("wr_data", 16'(reg_wr_data), 16'(e.d));
      end
      $display("reg_wr pulse addr=%h data=%h", reg_wr_addr, reg_wr_data);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'hFF;
    for (int i = 0; i < nbits; i++) begin
      spi_sck  = 1'b0;
      spi_mosi = tx[7-i];
      repeat (10) @(negedge clk);
      spi_sck   = 1'b1;
      rx[7-i]   = spi_miso;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, input logic chk, input string tag);
    logic [7:0] rx;
    spi_bits(tx, 8, rx);
    if (chk) check(tag, 16'(rx), 16'(miso_q.pop_front()));
    $display("spi byte mosi=%h miso=%h", tx, rx);
  endtask

  task automatic spi_begin();
    spi_ss = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic spi_end();
    spi_ss = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic host_write(input logic [6:0] a, input logic [7:0] d);
    host_addr  = a;
    host_wdata = d;
    host_we    = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
    $display("host write addr=%h data=%h", a, d);
  endtask

  task automatic host_read(input logic [6:0] a, input logic [7:0] exp, input string tag);
    host_addr = a;
    @(negedge clk);
    check(tag, 16'(host_rdata), 16'(exp));
    $display("host read addr=%h data=%h", a, host_rdata);
  endtask

  initial begin
    logic [7:0] rx;
    host_addr = 7'h75;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_miso", 16'(spi_miso), 16'h1);
    check("rst_frame_active", 16'(frame_active), 16'h0);
    check("rst_wr_valid", 16'(reg_wr_valid), 16'h0);
    check("rst_wr_addr", 16'(reg_wr_addr), 16'h0);
    check("rst_wr_data", 16'(reg_wr_data), 16'h0);
    check("rst_host_rdata", 16'(host_rdata), 16'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    host_read(7'h75, 8'h71, "whoami_host");
    host_read(7'h00, 8'h00, "reg00_reset");

    // WHOAMI read over SPI
    miso_q.push_back(8'hFF);
    miso_q.push_back(8'h71);
    spi_begin();
    check("frame_active_on", 16'(frame_active), 16'h1);
    spi_byte(8'hF5, 1'b1, "whoami_cmd_miso");
    spi_byte(8'hFF, 1'b1, "whoami_spi");
    spi_end();
    check("frame_active_off", 16'(frame_active), 16'h0);

    // Burst read of host-written sample bytes
    host_write(7'h3B, 8'h12);
    host_write(7'h3C, 8'h34);
    miso_q.push_back(8'hFF);
    miso_q.push_back(8'h12);
    miso_q.push_back(8'h34);
    spi_begin();
    spi_byte(8'hBB, 1'b1, "burst_cmd");
    spi_byte(8'hFF, 1'b1, "burst_b0");
    spi_byte(8'hFF, 1'b1, "burst_b1");
    spi_end();

    // Burst write with 127 -> 0 wrap
    wr_q.push_back('{a: 7'h7F, d: 8'hAA});
    wr_q.push_back('{a: 7'h00, d: 8'h55});
    spi_begin();
    spi_byte(8'h7F, 1'b0, "");
    spi_byte(8'hAA, 1'b0, "");
    spi_byte(8'h55, 1'b0, "");
    spi_end();
    check("wrap_pulses_seen", 16'(wr_q.size()), 16'h0);
    host_read(7'h00, 8'h55, "wrap_reg00");
    host_read(7'h7F, 8'hAA, "wrap_reg7f");

    // Writes to WHOAMI are dropped from both sides
    spi_begin();
    spi_byte(8'h75, 1'b0, "");
    spi_byte(8'hAB, 1'b0, "");
    spi_end();
    host_write(7'h75, 8'h99);
    host_read(7'h75, 8'h71, "whoami_protect");

    // Same-clk SPI and host write to 0x6B: SPI data must land
    wr_q.push_back('{a: 7'h6B, d: 8'h80});
    spi_begin();
    spi_byte(8'h6B, 1'b0, "");
    fork
      spi_byte(8'h80, 1'b0, "");
      begin
        // The last sck rise of the byte is driven 150 negedges in.
        // Hold host_we across the two clks that follow synchronization.
        repeat (151) @(negedge clk);
        host_addr  = 7'h6B;
        host_wdata = 8'h11;
        host_we    = 1'b1;
        repeat (2) @(negedge clk);
        host_we    = 1'b0;
      end
    join
    spi_end();
    host_read(7'h6B, 8'h80, "collision_spi_wins");

    // The read snapshot is stable against a mid-byte host write.
    // A write to the next address shows up in the next byte.
    host_write(7'h20, 8'hA5);
    miso_q.push_back(8'hFF);
    miso_q.push_back(8'hA5);
    miso_q.push_back(8'hC3);
    spi_begin();
    spi_byte(8'hA0, 1'b1, "snap_cmd");
    fork
      spi_byte(8'hFF, 1'b1, "snap_stable");
      begin
        repeat (70) @(negedge clk);
        host_write(7'h20, 8'h5A);
        host_write(7'h21, 8'hC3);
      end
    join
    spi_byte(8'hFF, 1'b1, "snap_next");
    spi_end();
    miso_q.push_back(8'hFF);
    miso_q.push_back(8'h5A);
    spi_begin();
    spi_byte(8'hA0, 1'b1, "reread_cmd");
    spi_byte(8'hFF, 1'b1, "reread_new");
    spi_end();

    // Aborted write: partial byte discarded, FSM idles within 3 clk
    host_write(7'h1A, 8'h3C);
    spi_begin();
    spi_byte(8'h1A, 1'b0, "");
    spi_bits(8'hF0, 4, rx);
    spi_ss = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_frame_active", 16'(frame_active), 16'h0);
    repeat (10) @(negedge clk);
    host_read(7'h1A, 8'h3C, "abort_reg_kept");

    // Reset in the middle of a read of 0x20 (0x5A).
    // After 3 bits, MISO is driving a 0.
    spi_begin();
    spi_byte(8'hA0, 1'b0, "");
    spi_bits(8'hFF, 3, rx);
    check("pre_reset_miso", 16'(spi_miso), 16'h0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_miso", 16'(spi_miso), 16'h1);
    check("midrst_frame_active", 16'(frame_active), 16'h0);
    host_addr = 7'h20;
    @(negedge clk);
    check("midrst_host_rdata", 16'(host_rdata), 16'h0);
    rst_n = 1'b1;
    // ss is still low: the block must not start a frame
    repeat (20) @(negedge clk);
    check("rst_ss_low_idle", 16'(frame_active), 16'h0);
    host_read(7'h20, 8'h00, "midrst_reg20");
    host_read(7'h3B, 8'h00, "midrst_reg3b");
    host_read(7'h75, 8'h71, "midrst_whoami");
    spi_end();

    miso_q.push_back(8'hFF);
    miso_q.push_back(8'h71);
    spi_begin();
    spi_byte(8'hF5, 1'b1, "post_rst_cmd");
    spi_byte(8'hFF, 1'b1, "post_rst_whoami");
    spi_end();

    wr_q.push_back('{a: 7'h01, d: 8'h77});
    spi_begin();
    spi_byte(8'h01, 1'b0, "");
    spi_byte(8'h77, 1'b0, "");
    spi_end();
    host_read(7'h01, 8'h77, "post_rst_write");
    check("wr_queue_drained", 16'(wr_q.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
